phy_demux_lanes: RTL and testbench

Parametrised 1-to-LANES word demultiplexer for the PHY receive path. It collects consecutive valid words from the serial-side stream into a LANES-wide parallel group and emits each group with a one-cycle strobe. Unlike the fixed 4-lane multi-clock demux, it runs on a single clock. It honours an input valid qualifier, flushes partial groups on request, and reports which lanes of a group carry real data.

---
 rtl/phy_demux_lanes.sv | 108 ++++++++++
 tb/tb_phy_demux_lanes.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_demux_lanes.sv
// phy_demux_lanes: single-clock 1-to-LANES word demultiplexer for the PHY receive path.
// Consecutive valid words are packed into a LANES-wide group. The group is emitted on
// out_data/out_valid with a one-cycle out_strobe when it fills or is flushed.
//
// Handshake: in_valid is a pure qualifier with no backpressure. A word is taken on every
// rising clk_f edge where in_valid=1. The downstream side must consume out_data/out_valid
// on the cycle out_strobe=1. Those outputs hold until the next strobe.
module phy_demux_lanes #(
  parameter int DW    = 8,
  parameter int LANES = 4,
  parameter int PW    = $clog2(LANES)
) (
  input  logic                clk_f,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  input  logic                flush,
  output logic [LANES*DW-1:0] out_data,
  output logic [LANES-1:0]    out_valid,
  output logic                out_strobe,
  output logic [PW-1:0]       lane_ptr,
  output logic [15:0]         group_cnt
);

  localparam logic [PW-1:0] LastLane = PW'(LANES - 1);

  // Assembly state. The fill state is implicit in ptr_q (FILL_0..FILL_LANES-1) and is
  // visible on lane_ptr.
  logic [DW-1:0]       sh_q [LANES];
  logic [DW-1:0]       sh_d [LANES];
  logic [LANES-1:0]    pm_q, pm_d;
  logic [PW-1:0]       ptr_q, ptr_d;
  logic [LANES*DW-1:0] out_data_q, out_data_d;
  logic [LANES-1:0]    out_valid_q, out_valid_d;
  logic                out_strobe_q, out_strobe_d;
  logic [15:0]         group_cnt_q, group_cnt_d;

  logic [LANES-1:0]    fill_mask;
  logic                full_close;
  logic                flush_close;

  // Next state: write the incoming word, then close the group if it is full or flushed.
  always_comb begin
    sh_d         = sh_q;
    pm_d         = pm_q;
    ptr_d        = ptr_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    out_strobe_d = 1'b0;
    group_cnt_d  = group_cnt_q;
    fill_mask    = pm_q;

    if (in_valid) begin
      sh_d[ptr_q]      = in_data;
      fill_mask[ptr_q] = 1'b1;
      ptr_d            = ptr_q + 1'b1;
    end
    pm_d = fill_mask;

    // A flush that coincides with a full close adds nothing: it is the same single close.
    full_close  = in_valid && (ptr_q == LastLane);
    flush_close = flush && ((pm_q != '0) || in_valid);

    if (full_close || flush_close) begin
      for (int k = 0; k < LANES; k++) begin
        out_data_d[k*DW +: DW] = fill_mask[k] ? sh_d[k] : '0;
      end
      out_valid_d  = fill_mask;
      out_strobe_d = 1'b1;
      group_cnt_d  = group_cnt_q + 16'd1;
      ptr_d        = '0;
      pm_d         = '0;
    end
  end

  // State and output registers. Reset takes priority over in_valid and flush,
  // and it discards any partial group without a strobe.
  always_ff @(posedge clk_f) begin
    if (reset) begin
      for (int k = 0; k < LANES; k++) begin
        sh_q[k] <= '0;
      end
      pm_q         <= '0;
      ptr_q        <= '0;
      out_data_q   <= '0;
      out_valid_q  <= '0;
      out_strobe_q <= 1'b0;
      group_cnt_q  <= '0;
    end else begin
      for (int k = 0; k < LANES; k++) begin
        sh_q[k] <= sh_d[k];
      end
      pm_q         <= pm_d;
      ptr_q        <= ptr_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      out_strobe_q <= out_strobe_d;
      group_cnt_q  <= group_cnt_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_strobe = out_strobe_q;
  assign lane_ptr   = ptr_q;
  assign group_cnt  = group_cnt_q;

endmodule

// File: tb/tb_phy_demux_lanes.sv
// Bench for phy_demux_lanes.
// Covers two configurations: LANES=4/DW=8 and LANES=8/DW=4 (lane packing and group_cnt wrap).
module tb_phy_demux_lanes;

  // ---------------- clock / reset ----------------
  logic clk_f = 1'b0;
  always #5 clk_f = ~clk_f;

  int checks   = 0;
  int failures = 0;

  // Instance A: LANES=4, DW=8.
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        flush = 1'b0;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic        out_strobe;
  logic [1:0]  lane_ptr;
  logic [15:0] group_cnt;

  phy_demux_lanes #(.DW(8), .LANES(4)) dut (
    .clk_f(clk_f), .reset(reset), .in_valid(in_valid), .in_data(in_data), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_strobe(out_strobe),
    .lane_ptr(lane_ptr), .group_cnt(group_cnt)
  );

  // Instance B: LANES=8, DW=4.
  logic        w_reset = 1'b1;
  logic        w_valid = 1'b0;
  logic [3:0]  w_data = '0;
  logic        w_flush = 1'b0;
  logic [31:0] w_out_data;
  logic [7:0]  w_out_valid;
  logic        w_out_strobe;
  logic [2:0]  w_lane_ptr;
  logic [15:0] w_group_cnt;

  phy_demux_lanes #(.DW(4), .LANES(8)) dut8 (
    .clk_f(clk_f), .reset(w_reset), .in_valid(w_valid), .in_data(w_data), .flush(w_flush),
    .out_data(w_out_data), .out_valid(w_out_valid), .out_strobe(w_out_strobe),
    .lane_ptr(w_lane_ptr), .group_cnt(w_group_cnt)
  );

  // ---------------- reference model (instance A) ----------------
  // Words of the open group are held in a queue. A group closes when it holds 4 words,
  // or on a flush while it is non-empty.
  logic [7:0]  cur_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] m_data   = '0;
  logic [3:0]  m_valid  = '0;
  logic        m_strobe = 1'b0;
  logic [15:0] m_cnt    = '0;
  int          m_ptr    = 0;

  // ---------------- driver ----------------
  task automatic step(input logic v, input logic [7:0] d, input logic f, input logic r);
    in_valid = v; in_data = d; flush = f; reset = r;
    @(posedge clk_f);
    #1;
    if (r) begin
      cur_q.delete();
      m_data = '0; m_valid = '0; m_strobe = 1'b0; m_cnt = '0;
    end else begin
      if (v) cur_q.push_back(d);
      if (cur_q.size() == 4 || (f && cur_q.size() != 0)) begin
        m_data = '0; m_valid = '0;
        foreach (cur_q[i]) begin
          m_data[i*8 +: 8] = cur_q[i];
          m_valid[i] = 1'b1;
        end
        m_strobe = 1'b1;
        m_cnt = m_cnt + 16'd1;
        exp_q.push_back(m_data);
        cur_q.delete();
      end else begin
        m_strobe = 1'b0;
      end
    end
    m_ptr = cur_q.size();
    in_valid = 1'b0; flush = 1'b0; reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    w_reset = 1'b1;
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b1, 8'hEE, 1'b0, 1'b1);
    w_reset = 1'b0;
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", out_data); end
    checks++; if (out_valid !== 4'h0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_strobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%b exp=0", out_strobe); end
    checks++; if (lane_ptr !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", lane_ptr); end
    checks++; if (group_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", group_cnt); end
    checks++; if (w_group_cnt !== 16'd0 || w_out_valid !== 8'h0) begin failures++; $display("FAIL reset_w got cnt=%0d valid=%b exp=0", w_group_cnt, w_out_valid); end
  endtask

  task automatic test_full_group();
    logic [7:0] words [4];
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, words[i], 1'b0, 1'b0);
      if (i < 3) begin
        checks++; if (out_strobe !== 1'b0 || lane_ptr !== 2'(i + 1)) begin failures++; $display("FAIL full_fill%0d got strobe=%b ptr=%0d exp strobe=0 ptr=%0d", i, out_strobe, lane_ptr, i + 1); end
      end
    end
    checks++; if (out_strobe !== 1'b1) begin failures++; $display("FAIL full_strobe got=%b exp=1", out_strobe); end
    checks++; if (out_data !== 32'h44332211) begin failures++; $display("FAIL full_data got=%h exp=44332211", out_data); end
    checks++; if (out_valid !== 4'b1111) begin failures++; $display("FAIL full_valid got=%b exp=1111", out_valid); end
    checks++; if (group_cnt !== 16'd1) begin failures++; $display("FAIL full_cnt got=%0d exp=1", group_cnt); end
    checks++; if (lane_ptr !== 2'd0) begin failures++; $display("FAIL full_ptr got=%0d exp=0", lane_ptr); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (out_strobe !== 1'b0 || out_data !== 32'h44332211) begin failures++; $display("FAIL full_hold got strobe=%b data=%h exp strobe=0 data=44332211", out_strobe, out_data); end
  endtask

  task automatic test_back_to_back();
    int strobes = 0;
    int last_at = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      if (out_strobe === 1'b1) begin
        if (last_at >= 0) begin
          checks++; if (i - last_at !== 4) begin failures++; $display("FAIL b2b_spacing got=%0d exp=4", i - last_at); end
        end
        strobes++; last_at = i;
      end
      if (i == 4) begin
        checks++; if (out_strobe !== 1'b1 || out_data !== 32'h04030201) begin failures++; $display("FAIL b2b_first got strobe=%b data=%h exp strobe=1 data=04030201", out_strobe, out_data); end
      end else if (i == 8) begin
        checks++; if (out_strobe !== 1'b1 || out_data !== 32'h08070605) begin failures++; $display("FAIL b2b_second got strobe=%b data=%h exp strobe=1 data=08070605", out_strobe, out_data); end
      end else if (i > 4) begin
        checks++; if (out_strobe !== 1'b0 || out_data !== 32'h04030201) begin failures++; $display("FAIL b2b_hold%0d got strobe=%b data=%h exp strobe=0 data=04030201", i, out_strobe, out_data); end
      end
    end
    checks++; if (strobes !== 2) begin failures++; $display("FAIL b2b_count got=%0d exp=2", strobes); end
    checks++; if (group_cnt !== m_cnt) begin failures++; $display("FAIL b2b_cnt got=%0d exp=%0d", group_cnt, m_cnt); end
  endtask

  task automatic test_flush_partial();
    logic [15:0] cnt_before;
    step(1'b1, 8'hAA, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 8'hBB, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (lane_ptr !== 2'd2 || out_strobe !== 1'b0) begin failures++; $display("FAIL fp_gap got ptr=%0d strobe=%b exp ptr=2 strobe=0", lane_ptr, out_strobe); end
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (out_strobe !== 1'b1) begin failures++; $display("FAIL fp_strobe got=%b exp=1", out_strobe); end
    checks++; if (out_data !== 32'h0000BBAA) begin failures++; $display("FAIL fp_data got=%h exp=0000bbaa", out_data); end
    checks++; if (out_valid !== 4'b0011) begin failures++; $display("FAIL fp_valid got=%b exp=0011", out_valid); end
    checks++; if (lane_ptr !== 2'd0) begin failures++; $display("FAIL fp_ptr got=%0d exp=0", lane_ptr); end
    cnt_before = group_cnt;
    step(1'b0, 8'h00, 1'b1, 1'b0);
    checks++; if (out_strobe !== 1'b0 || group_cnt !== cnt_before || out_data !== 32'h0000BBAA) begin failures++; $display("FAIL fp_empty got strobe=%b cnt=%0d data=%h exp strobe=0 cnt=%0d data=0000bbaa", out_strobe, group_cnt, out_data, cnt_before); end
  endtask

  task automatic test_flush_full();
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    checks++; if (lane_ptr !== 2'd3) begin failures++; $display("FAIL ff_ptr got=%0d exp=3", lane_ptr); end
    step(1'b1, 8'hCC, 1'b1, 1'b0);
    checks++; if (out_strobe !== 1'b1 || out_data !== 32'hCC030201 || out_valid !== 4'hF) begin failures++; $display("FAIL ff_group got strobe=%b data=%h valid=%b exp 1 cc030201 1111", out_strobe, out_data, out_valid); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (out_strobe !== 1'b0 || group_cnt !== m_cnt) begin failures++; $display("FAIL ff_single got strobe=%b cnt=%0d exp strobe=0 cnt=%0d", out_strobe, group_cnt, m_cnt); end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'h55, 1'b0, 1'b0);
    step(1'b1, 8'h66, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    checks++; if (out_data !== 32'h0 || out_valid !== 4'h0 || out_strobe !== 1'b0 || lane_ptr !== 2'd0 || group_cnt !== 16'd0) begin failures++; $display("FAIL rm_zero got data=%h valid=%b strobe=%b ptr=%0d cnt=%0d exp all 0", out_data, out_valid, out_strobe, lane_ptr, group_cnt); end
    step(1'b0, 8'h00, 1'b0, 1'b0);
    checks++; if (out_strobe !== 1'b0) begin failures++; $display("FAIL rm_nostrobe got=%b exp=0", out_strobe); end
    step(1'b1, 8'h9A, 1'b0, 1'b0);
    step(1'b1, 8'h9B, 1'b0, 1'b0);
    step(1'b1, 8'h9C, 1'b0, 1'b0);
    step(1'b1, 8'h9D, 1'b0, 1'b0);
    checks++; if (out_strobe !== 1'b1 || out_data !== 32'h9D9C9B9A || out_valid !== 4'hF || group_cnt !== 16'd1) begin failures++; $display("FAIL rm_clean got strobe=%b data=%h valid=%b cnt=%0d exp 1 9d9c9b9a 1111 1", out_strobe, out_data, out_valid, group_cnt); end
  endtask

  task automatic test_random();
    logic [31:0] exp_data;
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0, $urandom_range(0, 63) == 0);
      checks++; if (out_strobe !== m_strobe || out_valid !== m_valid || lane_ptr !== 2'(m_ptr) || group_cnt !== m_cnt) begin
        failures++; $display("FAIL rnd_ctrl%0d got strobe=%b valid=%b ptr=%0d cnt=%0d exp strobe=%b valid=%b ptr=%0d cnt=%0d", n, out_strobe, out_valid, lane_ptr, group_cnt, m_strobe, m_valid, m_ptr, m_cnt);
      end
      if (out_strobe === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_sb%0d got data=%h exp no strobe", n, out_data);
        end else begin
          exp_data = exp_q.pop_front();
          if (out_data !== exp_data) begin failures++; $display("FAIL rnd_sb%0d got data=%h exp=%h", n, out_data, exp_data); end
        end
      end else begin
        checks++; if (out_data !== m_data) begin failures++; $display("FAIL rnd_hold%0d got data=%h exp=%h", n, out_data, m_data); end
      end
    end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rnd_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  task automatic test_wide_wrap();
    logic [15:0] exp_cnt;
    logic [3:0]  d;
    for (int i = 1; i <= 8; i++) begin
      w_valid = 1'b1; w_data = 4'(i); w_flush = 1'b0;
      @(posedge clk_f); #1;
    end
    w_valid = 1'b0;
    checks++; if (w_out_strobe !== 1'b1 || w_out_data !== 32'h87654321 || w_out_valid !== 8'hFF || w_group_cnt !== 16'd1) begin
      failures++; $display("FAIL w_pack got strobe=%b data=%h valid=%b cnt=%0d exp 1 87654321 ff 1", w_out_strobe, w_out_data, w_out_valid, w_group_cnt);
    end
    exp_cnt = 16'd1;
    // 65535 single-word flushed groups; the last one wraps group_cnt to 0.
    for (int n = 0; n < 65535; n++) begin
      d = 4'($urandom_range(0, 15));
      w_valid = 1'b1; w_data = d; w_flush = 1'b1;
      @(posedge clk_f); #1;
      exp_cnt = exp_cnt + 16'd1;
      checks++; if (w_out_strobe !== 1'b1 || w_out_data !== {28'h0, d} || w_out_valid !== 8'h01 || w_group_cnt !== exp_cnt) begin
        failures++; $display("FAIL w_single%0d got strobe=%b data=%h valid=%b cnt=%0d exp 1 %h 01 %0d", n, w_out_strobe, w_out_data, w_out_valid, w_group_cnt, {28'h0, d}, exp_cnt);
      end
    end
    w_valid = 1'b0; w_flush = 1'b0;
    @(posedge clk_f); #1;
    checks++; if (w_group_cnt !== 16'd0 || w_out_strobe !== 1'b0) begin failures++; $display("FAIL w_wrap got cnt=%0d strobe=%b exp cnt=0 strobe=0", w_group_cnt, w_out_strobe); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_group();
    test_back_to_back();
    test_flush_partial();
    test_flush_full();
    test_reset_mid();
    test_random();
    test_wide_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
